// File: rtl/norm32_pipe.sv
// Two-stage mantissa normalizer: S1 counts leading zeros, S2 shifts and adjusts the exponent.
// Valid/ready handshake on both sides with full-throughput skid-free pipeline advance.
module norm32_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [7:0]  in_exp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [7:0]  out_exp,
   output logic [5:0]  out_lz,
   output logic        out_zero,
   output logic        out_uflow
);

   logic        s1_valid;
   logic [31:0] s1_data;
   logic [7:0]  s1_exp;
   logic [5:0]  s1_lz;
   logic        s1_zero;

   logic        s1_adv;
   logic        s2_adv;
   logic [5:0]  lz_c;
   logic [31:0] s2_data_d;
   logic [7:0]  s2_exp_d;
   logic        s2_uflow_d;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Highest set bit wins; an all-zero word keeps the default of 32.
   always_comb begin
      lz_c = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (in_data[i]) lz_c = 6'(31 - i);
      end
   end

   // Shift is clamped to the exponent so the result never goes below exponent 0.
   always_comb begin
      s2_data_d  = '0;
      s2_exp_d   = '0;
      s2_uflow_d = 1'b0;
      if (!s1_zero) begin
         if ({2'b00, s1_lz} <= s1_exp) begin
            s2_data_d = s1_data << s1_lz;
            s2_exp_d  = s1_exp - {2'b00, s1_lz};
         end else begin
            s2_data_d  = s1_data << s1_exp;
            s2_uflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_exp   <= '0;
         s1_lz    <= '0;
         s1_zero  <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_exp  <= in_exp;
            s1_lz   <= lz_c;
            s1_zero <= (in_data == 32'd0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_exp   <= '0;
         out_lz    <= '0;
         out_zero  <= 1'b0;
         out_uflow <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data  <= s2_data_d;
            out_exp   <= s2_exp_d;
            out_lz    <= s1_lz;
            out_zero  <= s1_zero;
            out_uflow <= s2_uflow_d;
         end
      end
   end

endmodule
